// File: rtl/dma_burst_writer.sv
// dma_burst_writer
//   Moves a block of words from the DMA scratch memory onto the shared bus
//   as a series of burst writes. Each burst re-arbitrates for the bus.
//
// Ports
//   clock, reset            : system clock; asynchronous active-high reset
//   startIn + config inputs : start pulse and transfer configuration
//                             (bus byte address, scratch word address,
//                             block size, burst size minus 1)
//   memAddressOut/memDataIn : scratch read port, data returns one cycle later
//   requestTransaction /
//   transactionGranted      : arbiter handshake
//   addressDataOut ...
//   endTransactionOut       : bus master signals (address in the begin cycle,
//                             then write beats)
//   busyIn, busErrorIn      : slave stall and slave error
//   busyOut/errorOut/doneOut: status for the custom-instruction register file
//   dbgStateOut             : current FSM state, for observation only
//
// Handshake: a write beat transfers on a rising edge where dataValidOut=1 and
// busyIn=0. While busyIn=1 the beat (dataValidOut, addressDataOut) is held.
module dma_burst_writer #(
  parameter int MEM_AW = 9,
  parameter int BLK_W  = 10
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              startIn,
  input  logic [31:0]       busStartAddressIn,
  input  logic [MEM_AW-1:0] memStartAddressIn,
  input  logic [BLK_W-1:0]  blockSizeIn,
  input  logic [7:0]        burstSizeIn,
  output logic [MEM_AW-1:0] memAddressOut,
  input  logic [31:0]       memDataIn,
  output logic              requestTransaction,
  input  logic              transactionGranted,
  output logic [31:0]       addressDataOut,
  output logic [3:0]        byteEnablesOut,
  output logic [7:0]        burstSizeOut,
  output logic              readNotWriteOut,
  output logic              beginTransactionOut,
  output logic              dataValidOut,
  output logic              endTransactionOut,
  input  logic              busyIn,
  input  logic              busErrorIn,
  output logic              busyOut,
  output logic              errorOut,
  output logic              doneOut,
  output logic [2:0]        dbgStateOut
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQUEST = 3'd1,
    S_INIT    = 3'd2,
    S_DATA    = 3'd3,
    S_END     = 3'd4,
    S_CHECK   = 3'd5,
    S_ERROR   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  localparam logic [BLK_W-1:0]  ONE_B = 1;
  localparam logic [MEM_AW-1:0] ONE_M = 1;

  state_t              r_state;
  logic [31:0]         r_bus_addr;
  logic [MEM_AW-1:0]   r_rd_addr;     // next scratch address to read
  logic [BLK_W-1:0]    r_remaining;
  logic [7:0]          r_burst;
  logic [BLK_W-1:0]    r_rd_cnt;      // reads issued in this burst
  logic [BLK_W-1:0]    r_beat_cnt;    // beats accepted in this burst
  logic                r_pend;        // read issued last cycle: memDataIn valid now
  logic [1:0]          r_cnt;         // prefetch entries held
  logic [31:0]         r_buf0;
  logic [31:0]         r_buf1;
  logic                r_err;
  logic                r_done;

  logic [BLK_W:0]      w_burst_words;
  logic                w_rem_lt;
  logic [BLK_W-1:0]    w_len;
  logic [7:0]          w_bsz;
  logic                w_in_burst;
  logic                w_valid;
  logic                w_accept;
  logic [31:0]         w_head;
  logic [2:0]          w_occ;
  logic                w_issue;
  logic                w_last;
  logic                w_pop;
  logic                w_push;
  logic                w_wr_slot;
  logic                w_bus_phase;

  // Burst length is the smaller of the configured burst and what is left.
  assign w_burst_words = {{(BLK_W-8){1'b0}}, 1'b0, r_burst} + {{BLK_W{1'b0}}, 1'b1};
  assign w_rem_lt      = ({1'b0, r_remaining} < w_burst_words);
  assign w_len         = w_rem_lt ? r_remaining : w_burst_words[BLK_W-1:0];
  assign w_bsz         = w_rem_lt ? (r_remaining[7:0] - 8'd1) : r_burst;

  // The head beat comes from the buffer, or straight from the scratch read
  // that is returning this cycle when the buffer is empty.
  assign w_in_burst = (r_state == S_INIT) || (r_state == S_DATA);
  assign w_valid    = (r_state == S_DATA) && ((r_cnt != 2'd0) || r_pend);
  assign w_accept   = w_valid && !busyIn;
  assign w_head     = (r_cnt != 2'd0) ? r_buf0 : memDataIn;

  // Occupancy once this cycle's accept is taken out (returning read included).
  // A new read is allowed only if its data is sure to find a free slot even
  // when the slave stalls from here on.
  assign w_occ   = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_accept};
  assign w_issue = w_in_burst && (r_rd_cnt < w_len) && (w_occ <= 3'd1);
  assign w_last  = w_accept && ((r_beat_cnt + ONE_B) == w_len);

  assign w_pop     = w_accept && (r_cnt != 2'd0);
  assign w_push    = r_pend && !(w_accept && (r_cnt == 2'd0));
  assign w_wr_slot = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && !w_pop);

  assign w_bus_phase = (r_state == S_INIT) || (r_state == S_DATA) || (r_state == S_END);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bus_addr  <= '0;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_burst     <= '0;
      r_rd_cnt    <= '0;
      r_beat_cnt  <= '0;
      r_pend      <= 1'b0;
      r_cnt       <= 2'd0;
      r_buf0      <= '0;
      r_buf1      <= '0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The cycle of the done pulse still counts as busy.
          if (startIn && !r_done) begin
            r_bus_addr  <= busStartAddressIn & 32'hFFFF_FFFC;
            r_rd_addr   <= memStartAddressIn;
            r_remaining <= blockSizeIn;
            r_burst     <= burstSizeIn;
            r_err       <= 1'b0;
            r_state     <= (blockSizeIn == '0) ? S_DONE : S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (transactionGranted) begin
            r_rd_cnt   <= '0;
            r_beat_cnt <= '0;
            r_cnt      <= 2'd0;
            r_pend     <= 1'b0;
            r_state    <= S_INIT;
          end
        end
        S_INIT: r_state <= S_DATA;
        S_DATA: begin
          if (w_pop) r_buf0 <= r_buf1;
          if (w_push) begin
            if (w_wr_slot) r_buf1 <= memDataIn;
            else           r_buf0 <= memDataIn;
          end
          if (w_push && !w_pop)      r_cnt <= r_cnt + 2'd1;
          else if (w_pop && !w_push) r_cnt <= r_cnt - 2'd1;
          if (w_accept) r_beat_cnt <= r_beat_cnt + ONE_B;
          if (w_last)   r_state    <= S_END;
        end
        S_END: r_state <= S_CHECK;
        S_CHECK: begin
          // Scratch address already advanced by the reads of this burst.
          r_bus_addr  <= r_bus_addr + {{(30-BLK_W){1'b0}}, w_len, 2'b00};
          r_remaining <= r_remaining - w_len;
          r_state     <= (r_remaining == w_len) ? S_DONE : S_REQUEST;
        end
        S_ERROR: r_state <= S_DONE;
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_issue) begin
        r_rd_addr <= r_rd_addr + ONE_M;
        r_rd_cnt  <= r_rd_cnt + ONE_B;
      end
      if (w_in_burst) r_pend <= w_issue;

      // A slave error abandons the rest of the block.
      if (busErrorIn && w_bus_phase) begin
        r_state <= S_ERROR;
        r_err   <= 1'b1;
        r_pend  <= 1'b0;
        r_cnt   <= 2'd0;
      end
    end
  end

  always_comb begin
    requestTransaction  = 1'b0;
    addressDataOut      = 32'd0;
    byteEnablesOut      = 4'h0;
    burstSizeOut        = 8'd0;
    readNotWriteOut     = 1'b0;
    beginTransactionOut = 1'b0;
    dataValidOut        = 1'b0;
    endTransactionOut   = 1'b0;
    case (r_state)
      S_REQUEST: requestTransaction = 1'b1;
      S_INIT: begin
        requestTransaction  = 1'b1;
        beginTransactionOut = 1'b1;
        addressDataOut      = r_bus_addr;
        byteEnablesOut      = 4'hF;
        burstSizeOut        = w_bsz;
      end
      S_DATA: begin
        requestTransaction = 1'b1;
        dataValidOut       = w_valid;
        addressDataOut     = w_valid ? w_head : 32'd0;
      end
      S_END: begin
        requestTransaction = 1'b1;
        endTransactionOut  = 1'b1;
      end
      default: ;
    endcase
  end

  assign memAddressOut = r_rd_addr;
  assign busyOut       = (r_state != S_IDLE) || r_done;
  assign errorOut      = r_err;
  assign doneOut       = r_done;
  assign dbgStateOut   = r_state;

endmodule

// File: doc/dma_burst_writer.md
Name: dma_burst_writer

Overview:
- Write-direction companion to the CI-controlled DMA read engine: moves a block of words from the 512x32 DMA scratch memory onto the shared bus as burst writes.
- Reads scratch memory through its second read/write port and acts as bus master behind the same arbiter.
- Configured and kicked off by the DMA custom-instruction register file, which also reads back its busy/error/done state.

Parameters:
- MEM_AW, 9, scratch memory address width (words).
- BLK_W, 10, block-size counter width (words).

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- startIn  in  1  one-cycle pulse starting a transfer; ignored while busyOut=1
- busStartAddressIn  in  32  bus byte address of the first word; bits[1:0] ignored
- memStartAddressIn  in  MEM_AW  scratch word address of the first word
- blockSizeIn  in  BLK_W  total words to transfer
- burstSizeIn  in  8  max words per burst minus 1
- memAddressOut  out  MEM_AW  scratch read address
- memDataIn  in  32  scratch read data, valid one cycle after address
- requestTransaction  out  1  bus request to arbiter
- transactionGranted  in  1  arbiter grant
- addressDataOut  out  32  address in begin cycle, then write data
- byteEnablesOut  out  4  4'hF in begin cycle, else 0
- burstSizeOut  out  8  burst words minus 1, valid in begin cycle, else 0
- readNotWriteOut  out  1  always 0 in begin cycle, else 0
- beginTransactionOut  out  1  one-cycle begin strobe
- dataValidOut  out  1  write beat valid
- endTransactionOut  out  1  one-cycle end strobe
- busyIn  in  1  slave stall: beat not accepted
- busErrorIn  in  1  slave bus error
- busyOut  out  1  transfer in progress
- errorOut  out  1  sticky error flag, cleared by next accepted startIn
- doneOut  out  1  one-cycle pulse when transfer finishes, with or without error

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE, asynchronously. Reset mid-transfer aborts the transfer; no end strobe is issued.
- Start latches all config inputs into internal registers.
  - Word address = busStartAddressIn & ~3.
  - Remaining count = blockSizeIn.
  - busyOut rises the next cycle.
- blockSize=0: go IDLE->DONE, doneOut=1 two cycles after start, no bus request.
- FSM states: IDLE, REQUEST, INIT_BURST, DATA, END, CHECK, ERROR, DONE.
- REQUEST: requestTransaction=1 until transactionGranted=1, then INIT_BURST. requestTransaction stays high through END.
- INIT_BURST (1 cycle):
  - beginTransactionOut=1, addressDataOut=current bus address, byteEnablesOut=4'hF, readNotWriteOut=0.
  - burstSizeOut = len-1, where len = min(burstSize+1, remaining).
  - The first scratch read is issued this cycle.
- DATA:
  - Beats come from a 2-entry prefetch buffer fed by scratch reads (1-cycle latency).
  - dataValidOut=1 whenever the buffer is non-empty.
  - A beat is accepted on a rising edge with dataValidOut=1 and busyIn=0.
  - While busyIn=1, dataValidOut and addressDataOut hold stable.
  - Throughput is 1 beat/cycle without stalls; the first beat is on the cycle after INIT_BURST.
  - Never issue more reads than len per burst; the buffer never overflows.
- After the len-th beat is accepted: go to END, where endTransactionOut=1 for one cycle and all data outputs are 0.
- CHECK: bus address += 4*len, mem address += len (wraps mod 512), remaining -= len.
  - remaining=0 goes to DONE; otherwise go to REQUEST (re-arbitrate per burst).
- DONE: doneOut=1 for one cycle, busyOut=0 from the next cycle, then IDLE.
- busErrorIn=1 in any of INIT_BURST/DATA/END:
  - Drop requestTransaction, dataValidOut and endTransactionOut next cycle; set errorOut.
  - Go ERROR (1 cycle), then DONE. Remaining words are not sent.
- startIn in the same cycle as DONE is ignored; startIn is accepted only in IDLE.
- Bus address wraps naturally at 32 bits with no carry out.
- busyOut=1 in every state except IDLE.

Test Plan:
- Start with mem=0x010, bus=0x0000_1000, block=8, burst=3, no stalls -> two bursts.
  - Burst 1: begin addr 0x1000 with burstSizeOut=3; burst 2: begin addr 0x1010 with burstSizeOut=3.
  - Beats carry scratch[0x10..0x17] in order, one end strobe per burst.
  - doneOut fires once and errorOut=0.
- block=5, burst=3 -> bursts of 4 words then 1 word (burstSizeOut=3 then 0); second address 0x1010.
- busyIn high for 3 cycles on beat 2 -> beat 2 data held for 4 cycles; no beat lost or duplicated; total 8 beats accepted.
- Mem start 0x1FE, block=4, burst=7 -> beats from scratch 0x1FE, 0x1FF, 0x000, 0x001.
- busErrorIn on beat 3 of a 4-word burst -> no further beats or requests; errorOut=1, doneOut pulse.
  - Next startIn clears errorOut.
- Reset asserted mid-DATA -> all outputs 0 immediately, busyOut=0.
  - Also covered: block=0 start -> doneOut two cycles later, requestTransaction never asserted.
